ext_bus_avalon_bridge: RTL and testbench



---
 rtl/ext_bus_avalon_bridge.sv | 165 ++++++++++++++++
 tb/tb_ext_bus_avalon_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_avalon_bridge.sv
// External 4-phase req/ack bus to Avalon-MM master bridge, one transfer at a time.
// Optional hung-slave timeout enabled by defining EXT_BRIDGE_TIMEOUT_EN.
module ext_bus_avalon_bridge #(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 30,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA       = {DATA_W{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     ext_address,
    input  logic [DATA_W/8-1:0]   ext_byte_enable,
    input  logic                  ext_read,
    input  logic                  ext_write,
    input  logic [DATA_W-1:0]     ext_write_data,
    output logic                  ext_acknowledge,
    output logic [DATA_W-1:0]     ext_read_data,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  busy,
    output logic                  timeout_flag
);

    // state  | meaning
    // IDLE   | waiting for exactly one of ext_read/ext_write
    // REQ    | Avalon strobe asserted until waitrequest drops
    // RDWAIT | read accepted, waiting for readdatavalid
    // ACK    | transfer finished, waiting for request to drop
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    localparam int BE_W = DATA_W / 8;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;

`ifdef EXT_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tflag_q, tflag_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ext_read ^ ext_write) begin
                    state_d = ST_REQ;
                    addr_d  = ext_address;
                    be_d    = ext_byte_enable;
                    wdata_d = ext_write_data;
                    rd_d    = ext_read;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    if (!rd_q) begin
                        state_d = ST_ACK;
                    end else if (avm_readdatavalid) begin
                        rdata_d = avm_readdata;
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end
            end
            ST_RDWAIT: begin
                if (avm_readdatavalid) begin
                    rdata_d = avm_readdata;
                    state_d = ST_ACK;
                end
            end
            default: begin
                if (!ext_read && !ext_write) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

`ifdef EXT_BRIDGE_TIMEOUT_EN
        tflag_d = tflag_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_REQ || state_q == ST_RDWAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            // a normal completion on the same edge takes precedence over the timeout
            if (state_d != ST_ACK && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_ACK;
                tflag_d = 1'b1;
                if (rd_q) begin
                    rdata_d = ERR_DATA;
                end
            end
        end
`endif

        // ack shows from the second ACK cycle and drops on the edge that sees the request gone
        ack_d = (state_q == ST_ACK) && (ext_read || ext_write);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

`ifdef EXT_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            tflag_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tflag_q <= tflag_d;
        end
    end

    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign avm_read        = (state_q == ST_REQ) && rd_q;
    assign avm_write       = (state_q == ST_REQ) && !rd_q;
    assign avm_address     = addr_q;
    assign avm_byteenable  = be_q;
    assign avm_writedata   = wdata_q;
    assign ext_acknowledge = ack_q;
    assign ext_read_data   = rdata_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ext_bus_avalon_bridge.sv
// Bench for ext_bus_avalon_bridge: transaction-level reference model plus directed vectors.
module tb_ext_bus_avalon_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 16;
    localparam logic [DW-1:0] ERR = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] ext_address = '0;
    logic [BW-1:0] ext_byte_enable = '0;
    logic          ext_read = 1'b0;
    logic          ext_write = 1'b0;
    logic [DW-1:0] ext_write_data = '0;
    logic          ext_acknowledge;
    logic [DW-1:0] ext_read_data;
    logic [AW-1:0] avm_address;
    logic [BW-1:0] avm_byteenable;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic          avm_waitrequest = 1'b0;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic          busy;
    logic          timeout_flag;

    always #5 clk = ~clk;

    ext_bus_avalon_bridge #(
        .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ext_address(ext_address), .ext_byte_enable(ext_byte_enable),
        .ext_read(ext_read), .ext_write(ext_write), .ext_write_data(ext_write_data),
        .ext_acknowledge(ext_acknowledge), .ext_read_data(ext_read_data),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .timeout_flag(timeout_flag)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Transaction view: a transfer is open, its Avalon handshake is done or not,
    // its result is in or not; ack is seen once the result has been in for an edge.
    logic          m_active, m_accepted, m_done, m_ack, m_rd, m_tflag;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_wd, m_rdata;
    int            m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_accepted = 0; m_done = 0; m_ack = 0; m_rd = 0; m_tflag = 0;
            m_addr = '0; m_be = '0; m_wd = '0; m_rdata = '0; m_cnt = 0;
        end else if (!m_active) begin
            m_ack = 0;
            if (ext_read ^ ext_write) begin
                m_active = 1; m_accepted = 0; m_done = 0; m_cnt = 0;
                m_addr = ext_address; m_be = ext_byte_enable; m_wd = ext_write_data;
                m_rd = ext_read;
            end
        end else if (!m_done) begin
            m_cnt++;
            if (!m_accepted) begin
                if (!avm_waitrequest) begin
                    m_accepted = 1;
                    if (!m_rd) m_done = 1;
                    else if (avm_readdatavalid) begin m_rdata = avm_readdata; m_done = 1; end
                end
            end else if (avm_readdatavalid) begin
                m_rdata = avm_readdata; m_done = 1;
            end
`ifdef EXT_BRIDGE_TIMEOUT_EN
            if (!m_done && m_cnt >= TO) begin
                m_done = 1; m_accepted = 1; m_tflag = 1;
                if (m_rd) m_rdata = ERR;
            end
`endif
        end else begin
            if (!ext_read && !ext_write) begin m_active = 0; m_ack = 0; end
            else m_ack = 1;
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_active);
        check("avm_read", avm_read, m_active && !m_accepted && m_rd);
        check("avm_write", avm_write, m_active && !m_accepted && !m_rd);
        check("avm_address", avm_address, m_addr);
        check("avm_byteenable", avm_byteenable, m_be);
        check("avm_writedata", avm_writedata, m_wd);
        check("ext_acknowledge", ext_acknowledge, m_ack);
        check("ext_read_data", ext_read_data, m_rdata);
        check("timeout_flag", timeout_flag, m_tflag);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_strobes", {avm_read, avm_write}, 0);
        check("rst_ack", ext_acknowledge, 0);
        check("rst_rdata", ext_read_data, 0);
        check("rst_addr", avm_address, 0);
        reset_n = 1'b1;
        step();

        // minimum-latency write
        ext_address = 32'h100; ext_write_data = 32'hA5A5; ext_byte_enable = 4'b0011;
        ext_write = 1'b1;
        step();
        check("t1_write_hi", avm_write, 1);
        check("t1_addr", avm_address, 32'h100);
        check("t1_wdata", avm_writedata, 32'hA5A5);
        check("t1_be", avm_byteenable, 4'b0011);
        step();
        check("t1_write_lo", avm_write, 0);
        check("t1_ack_n1", ext_acknowledge, 0);
        step();
        check("t1_ack_n2", ext_acknowledge, 1);
        step();
        check("t1_ack_held", ext_acknowledge, 1);
        ext_write = 1'b0;
        step();
        check("t1_ack_drop", ext_acknowledge, 0);
        check("t1_idle", busy, 0);

        // read with 3 stall cycles, data two cycles after acceptance
        ext_address = 32'h200; ext_byte_enable = 4'hF; ext_read = 1'b1; avm_waitrequest = 1'b1;
        step();
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (avm_read) hi++;
            if (i == 3) avm_waitrequest = 1'b0;
            step();
        end
        check("t2_read_cycles", hi, 4);
        check("t2_read_lo", avm_read, 0);
        step();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h1234;
        step();
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        check("t2_ack_early", ext_acknowledge, 0);
        step();
        check("t2_ack", ext_acknowledge, 1);
        check("t2_rdata", ext_read_data, 32'h1234);
        ext_read = 1'b0;
        step();
        check("t2_ack_drop", ext_acknowledge, 0);

        // both requests high: illegal, ignored; stray readdatavalid in IDLE
        ext_read = 1'b1; ext_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_busy", busy, 0);
            check("t3_strobes", {avm_read, avm_write}, 0);
        end
        avm_readdatavalid = 1'b1; avm_readdata = 32'h0BAD;
        step();
        avm_readdatavalid = 1'b0;
        check("t3_rdata_kept", ext_read_data, 32'h1234);
        ext_read = 1'b0; ext_write = 1'b0;
        step();

        // write withdrawn while stalled: transfer completes, ack never shows
        ext_address = 32'h300; ext_write_data = 32'h55; ext_write = 1'b1; avm_waitrequest = 1'b1;
        step();
        check("tw_write_hi", avm_write, 1);
        ext_write = 1'b0;
        step();
        step();
        check("tw_still_hi", avm_write, 1);
        avm_waitrequest = 1'b0;
        step();
        check("tw_in_ack", {busy, ext_acknowledge}, 2'b10);
        step();
        check("tw_back_idle", {busy, ext_acknowledge}, 2'b00);

        // reset during RDWAIT
        ext_address = 32'h400; ext_read = 1'b1;
        step();
        step();
        check("t4_rdwait", {busy, avm_read}, 2'b10);
        reset_n = 1'b0; ext_read = 1'b0;
        #1;
        check("t4_async_busy", busy, 0);
        check("t4_async_rdata", ext_read_data, 0);
        check("t4_async_addr", avm_address, 0);
        step();
        step();
        reset_n = 1'b1; avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD;
        step();
        avm_readdatavalid = 1'b0;
        check("t4_late_rdv", ext_read_data, 0);
        ext_address = 32'h404; ext_read = 1'b1;
        step();
        avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFE_0001;
        step();
        avm_readdatavalid = 1'b0;
        step();
        check("t4_next_ack", ext_acknowledge, 1);
        check("t4_next_rdata", ext_read_data, 32'hCAFE_0001);
        ext_read = 1'b0;
        step();

        // full-width pass-through
        ext_address = 32'hFFFF_FFFC; ext_byte_enable = 4'b0110; ext_write_data = 32'hDEAD_BEEF;
        ext_write = 1'b1;
        step();
        check("t6_addr", avm_address, 32'hFFFF_FFFC);
        check("t6_be", avm_byteenable, 4'b0110);
        check("t6_wdata", avm_writedata, 32'hDEAD_BEEF);
        step();
        step();
        check("t6_wack", ext_acknowledge, 1);
        ext_write = 1'b0;
        step();
        ext_byte_enable = 4'hF; ext_read = 1'b1;
        step();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h89AB_CDEF;
        step();
        avm_readdatavalid = 1'b0;
        step();
        check("t6_rdata", ext_read_data, 32'h89AB_CDEF);
        ext_read = 1'b0;
        step();

`ifdef EXT_BRIDGE_TIMEOUT_EN
        // slave stuck in waitrequest
        ext_address = 32'h500; ext_read = 1'b1; avm_waitrequest = 1'b1;
        step();
        hi = 0;
        for (int i = 0; i < 40 && avm_read; i++) begin
            hi++;
            step();
        end
        check("t5_read_cycles", hi, TO);
        step();
        check("t5_ack", ext_acknowledge, 1);
        check("t5_err_data", ext_read_data, ERR);
        check("t5_flag", timeout_flag, 1);
        ext_read = 1'b0; avm_waitrequest = 1'b0;
        step();
        ext_address = 32'h504; ext_write = 1'b1;
        repeat (3) step();
        check("t5_write_ack", ext_acknowledge, 1);
        ext_write = 1'b0;
        step();
        check("t5_flag_sticky", timeout_flag, 1);
`else
        check("t5_flag_tied", timeout_flag, 0);
`endif

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
